// File: rtl/regfile_wb_scheduler_pkg.sv
// Purpose: shared constants and FSM state encoding for the register-file
// writeback scheduler and its scoreboard.
// Ports: none (package).
package regfile_wb_scheduler_pkg;

  localparam int NREGS  = 32;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2
  } wb_state_e;

endpackage

// File: rtl/regfile_wb_scheduler_wb_scoreboard.sv
// Purpose: per-register busy bits for long-latency-unit destinations that
// are still outstanding, plus the lookups the scheduler needs.
// Ports:
//   clk, rst                 clock, async active-high reset (clears all busy bits)
//   set_en, set_idx          mark a register busy (r0 is ignored)
//   clr_en, clr_idx          mark a register free
//   rs1, rs2                 decode-stage sources, drive hazard
//   issue_idx/pipe_idx/lu_idx lookups returning issue_busy/pipe_busy/lu_busy
//   hazard                   a nonzero rs1 or rs2 is busy
module wb_scoreboard
  import regfile_wb_scheduler_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_idx,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_idx,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] issue_idx,
  input  logic [ADDR_W-1:0] pipe_idx,
  input  logic [ADDR_W-1:0] lu_idx,
  output logic              hazard,
  output logic              issue_busy,
  output logic              pipe_busy,
  output logic              lu_busy
);

  logic [NREGS-1:0] busy_q, busy_d;

  // Set and clear of different registers in one cycle both take effect;
  // r0 can never become busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_en) busy_d[set_idx] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // Lookups use the registered bits, so a register being written back this
  // cycle still reads as busy until the next cycle.
  assign hazard     = ((rs1 != '0) && busy_q[rs1]) || ((rs2 != '0) && busy_q[rs2]);
  assign issue_busy = busy_q[issue_idx];
  assign pipe_busy  = busy_q[pipe_idx];
  assign lu_busy    = busy_q[lu_idx];

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Purpose: owns the single register-file write port, arbitrating it between
// the in-order pipeline writeback and the long-latency unit (LU). The LU is
// guaranteed service within MAX_WAIT+1 cycles by stalling the pipe once.
// Ports:
//   clk, rst                               clock, async active-high reset
//   pipe_wb_valid/rd/data, pipe_stall      pipeline writeback request / hold
//   lu_issue_valid/rd, lu_issue_ready      LU issue into the scoreboard
//   lu_wb_valid/rd/data, lu_wb_ready       LU result handshake
//   rs1, rs2, hazard                       decode-stage read hazard check
//   rf_we, rf_wr, rf_wd                    register file write port
//   err                                    sticky protocol error
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_wb_valid,
  input  logic [ADDR_W-1:0] pipe_wb_rd,
  input  logic [DATA_W-1:0] pipe_wb_data,
  output logic              pipe_stall,
  input  logic              lu_issue_valid,
  input  logic [ADDR_W-1:0] lu_issue_rd,
  output logic              lu_issue_ready,
  input  logic              lu_wb_valid,
  input  logic [ADDR_W-1:0] lu_wb_rd,
  input  logic [DATA_W-1:0] lu_wb_data,
  output logic              lu_wb_ready,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              hazard,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wr,
  output logic [DATA_W-1:0] rf_wd,
  output logic              err
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  wb_state_e         state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              err_q, err_d;
  logic              pipe_grant, lu_grant;
  logic              issue_busy, pipe_busy, lu_busy;

  // Arbiter: the pipe normally wins; wait_cnt counts consecutive cycles the
  // LU was blocked, and FORCE gives the LU one guaranteed slot. Grants are
  // suppressed while rst is high so nothing commits during reset.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    pipe_grant = 1'b0;
    lu_grant   = 1'b0;
    pipe_stall = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (lu_wb_valid && !pipe_wb_valid) begin
          lu_grant = 1'b1;
        end else if (lu_wb_valid && pipe_wb_valid) begin
          pipe_grant = 1'b1;
          wait_cnt_d = CNT_W'(1);
          state_d    = (wait_cnt_d >= CNT_W'(MAX_WAIT)) ? ST_FORCE : ST_WAIT;
        end else begin
          pipe_grant = pipe_wb_valid;
        end
      end
      ST_WAIT: begin
        if (!pipe_wb_valid) begin
          lu_grant   = lu_wb_valid;
          wait_cnt_d = '0;
          state_d    = ST_IDLE;
        end else begin
          pipe_grant = 1'b1;
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
          if (wait_cnt_d >= CNT_W'(MAX_WAIT)) state_d = ST_FORCE;
        end
      end
      ST_FORCE: begin
        lu_grant   = lu_wb_valid;
        pipe_stall = pipe_wb_valid;
        wait_cnt_d = '0;
        state_d    = ST_IDLE;
      end
      default: begin
        wait_cnt_d = '0;
        state_d    = ST_IDLE;
      end
    endcase
    if (rst) begin
      pipe_grant = 1'b0;
      lu_grant   = 1'b0;
      pipe_stall = 1'b0;
    end
  end

  // Protocol errors: the pipe overwriting a register the LU still owns, or an
  // LU result for a register that was never issued. r0 results are exempt
  // because r0 issues never mark busy.
  always_comb begin
    err_d = err_q;
    if (pipe_grant && pipe_busy) err_d = 1'b1;
    if (lu_wb_valid && (lu_wb_rd != '0) && !lu_busy) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  wb_scoreboard u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_en     (lu_issue_valid && lu_issue_ready),
    .set_idx    (lu_issue_rd),
    .clr_en     (lu_grant),
    .clr_idx    (lu_wb_rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .issue_idx  (lu_issue_rd),
    .pipe_idx   (pipe_wb_rd),
    .lu_idx     (lu_wb_rd),
    .hazard     (hazard),
    .issue_busy (issue_busy),
    .pipe_busy  (pipe_busy),
    .lu_busy    (lu_busy)
  );

  assign lu_issue_ready = !issue_busy;
  assign lu_wb_ready    = lu_grant;
  assign rf_we          = (pipe_grant && (pipe_wb_rd != '0)) || (lu_grant && (lu_wb_rd != '0));
  assign rf_wr          = lu_grant ? lu_wb_rd : pipe_wb_rd;
  assign rf_wd          = lu_grant ? lu_wb_data : pipe_wb_data;
  assign err            = err_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed scenarios for the writeback scheduler. Expected register-file
// writes are queued as stimulus is driven and compared whenever the DUT
// asserts rf_we; control outputs are checked directly each cycle.
module tb_regfile_wb_scheduler;
  import regfile_wb_scheduler_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pipe_wb_valid, lu_issue_valid, lu_wb_valid;
  logic [ADDR_W-1:0] pipe_wb_rd, lu_issue_rd, lu_wb_rd, rs1, rs2;
  logic [DATA_W-1:0] pipe_wb_data, lu_wb_data;
  logic              pipe_stall, lu_issue_ready, lu_wb_ready, hazard, rf_we, err;
  logic [ADDR_W-1:0] rf_wr;
  logic [DATA_W-1:0] rf_wd;

  int checks = 0;
  int errors = 0;
  logic [ADDR_W+DATA_W-1:0] wb_q[$];
  logic [ADDR_W+DATA_W-1:0] exp_wb;

  regfile_wb_scheduler #(.MAX_WAIT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .pipe_wb_valid  (pipe_wb_valid),
    .pipe_wb_rd     (pipe_wb_rd),
    .pipe_wb_data   (pipe_wb_data),
    .pipe_stall     (pipe_stall),
    .lu_issue_valid (lu_issue_valid),
    .lu_issue_rd    (lu_issue_rd),
    .lu_issue_ready (lu_issue_ready),
    .lu_wb_valid    (lu_wb_valid),
    .lu_wb_rd       (lu_wb_rd),
    .lu_wb_data     (lu_wb_data),
    .lu_wb_ready    (lu_wb_ready),
    .rs1            (rs1),
    .rs2            (rs2),
    .hazard         (hazard),
    .rf_we          (rf_we),
    .rf_wr          (rf_wr),
    .rf_wd          (rf_wd),
    .err            (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of inputs just after a posedge, then settles so the
  // combinational outputs can be checked well before the next edge.
  task automatic applyStimulus(input logic pv, input logic [ADDR_W-1:0] prd, input logic [DATA_W-1:0] pd,
                               input logic iv, input logic [ADDR_W-1:0] ird,
                               input logic lv, input logic [ADDR_W-1:0] lrd, input logic [DATA_W-1:0] ld,
                               input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
    pipe_wb_valid  = pv;
    pipe_wb_rd     = prd;
    pipe_wb_data   = pd;
    lu_issue_valid = iv;
    lu_issue_rd    = ird;
    lu_wb_valid    = lv;
    lu_wb_rd       = lrd;
    lu_wb_data     = ld;
    rs1            = r1;
    rs2            = r2;
    #2;
  endtask

  task automatic expectWrite(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] data);
    wb_q.push_back({rd, data});
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
  endtask

  // Every committed write must match the oldest expected write.
  always @(negedge clk) begin
    if (rf_we) begin
      if (wb_q.size() == 0) begin
        checkOutput("wb_spurious", 64'(rf_we), 64'(0));
      end else begin
        exp_wb = wb_q.pop_front();
        checkOutput("wb_commit", 64'({rf_wr, rf_wd}), 64'(exp_wb));
      end
    end
  end

  initial begin
    // Reset with requests present: nothing may be granted or committed.
    applyStimulus(1'b1, 5'd1, 32'h1, 1'b0, 5'd0, 1'b1, 5'd1, 32'h1, 5'd1, 5'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rst_rf_we", 64'(rf_we), 64'(0));
    checkOutput("rst_lu_ready", 64'(lu_wb_ready), 64'(0));
    checkOutput("rst_stall", 64'(pipe_stall), 64'(0));
    checkOutput("rst_err", 64'(err), 64'(0));
    checkOutput("rst_hazard", 64'(hazard), 64'(0));
    rst = 1'b0;

    // Scenario 1: issue r5, read hazard, LU writeback, hazard clears next cycle.
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    checkOutput("t1_issue_ready", 64'(lu_issue_ready), 64'(1));
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    checkOutput("t1_hazard", 64'(hazard), 64'(1));
    checkOutput("t1_busy_ready", 64'(lu_issue_ready), 64'(0));
    nextCycle();
    expectWrite(5'd5, 32'hDEAD);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 1'b1, 5'd5, 32'hDEAD, 5'd5, 5'd0);
    checkOutput("t1_lu_ready", 64'(lu_wb_ready), 64'(1));
    checkOutput("t1_rf_we", 64'(rf_we), 64'(1));
    checkOutput("t1_rf_wr", 64'(rf_wr), 64'(5));
    checkOutput("t1_hazard_during_wb", 64'(hazard), 64'(1));
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    checkOutput("t1_hazard_after", 64'(hazard), 64'(0));
    checkOutput("t1_ready_after", 64'(lu_issue_ready), 64'(1));
    nextCycle();

    // Scenario 2: pipe busy every cycle, LU r7 pending -> 4 pipe grants, then FORCE.
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    nextCycle();
    for (int k = 0; k < 4; k++) begin
      expectWrite(5'(10 + k), 32'hA000 + 32'(k));
      applyStimulus(1'b1, 5'(10 + k), 32'hA000 + 32'(k), 1'b0, 5'd0, 1'b1, 5'd7, 32'h7777, 5'd0, 5'd0);
      checkOutput("t2_pipe_no_stall", 64'(pipe_stall), 64'(0));
      checkOutput("t2_lu_blocked", 64'(lu_wb_ready), 64'(0));
      nextCycle();
    end
    expectWrite(5'd7, 32'h7777);
    applyStimulus(1'b1, 5'd14, 32'hA004, 1'b0, 5'd0, 1'b1, 5'd7, 32'h7777, 5'd0, 5'd0);
    checkOutput("t2_force_lu_ready", 64'(lu_wb_ready), 64'(1));
    checkOutput("t2_force_stall", 64'(pipe_stall), 64'(1));
    checkOutput("t2_force_rf_wr", 64'(rf_wr), 64'(7));
    nextCycle();
    expectWrite(5'd14, 32'hA004);
    applyStimulus(1'b1, 5'd14, 32'hA004, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    checkOutput("t2_pipe_resume", 64'(pipe_stall), 64'(0));
    checkOutput("t2_lu_done", 64'(lu_wb_ready), 64'(0));
    nextCycle();

    // Scenario 3: writes to r0 complete their handshakes but never commit.
    applyStimulus(1'b1, 5'd0, 32'h1111, 1'b0, 5'd0, 1'b1, 5'd0, 32'h2222, 5'd0, 5'd0);
    checkOutput("t3_pipe_r0_we", 64'(rf_we), 64'(0));
    checkOutput("t3_pipe_r0_accept", 64'(pipe_stall), 64'(0));
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd0, 32'h2222, 5'd0, 5'd0);
    checkOutput("t3_lu_r0_ready", 64'(lu_wb_ready), 64'(1));
    checkOutput("t3_lu_r0_we", 64'(rf_we), 64'(0));
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    nextCycle();
    idle();
    checkOutput("t3_r0_not_busy", 64'(lu_issue_ready), 64'(1));
    checkOutput("t3_err_clear", 64'(err), 64'(0));
    nextCycle();

    // Scenario 4: set r3 and clear r9 in the same cycle.
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    nextCycle();
    expectWrite(5'd9, 32'h9999);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd9, 32'h9999, 5'd0, 5'd0);
    checkOutput("t4_lu_ready", 64'(lu_wb_ready), 64'(1));
    checkOutput("t4_issue_ready", 64'(lu_issue_ready), 64'(1));
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd0, 32'h0, 5'd3, 5'd9);
    checkOutput("t4_r3_busy", 64'(lu_issue_ready), 64'(0));
    checkOutput("t4_hazard_r3", 64'(hazard), 64'(1));
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
    checkOutput("t4_r9_clear", 64'(hazard), 64'(0));
    nextCycle();
    expectWrite(5'd3, 32'h3333);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd3, 32'h3333, 5'd0, 5'd0);
    checkOutput("t4_retire_r3", 64'(lu_wb_ready), 64'(1));
    nextCycle();
    idle();
    checkOutput("t4_err_clear", 64'(err), 64'(0));
    nextCycle();

    // Scenario 5: WAW from the pipe sets err; it stays set.
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    nextCycle();
    expectWrite(5'd4, 32'h4444);
    applyStimulus(1'b1, 5'd4, 32'h4444, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    checkOutput("t5_err_before", 64'(err), 64'(0));
    nextCycle();
    idle();
    checkOutput("t5_err_set", 64'(err), 64'(1));
    nextCycle();
    expectWrite(5'd4, 32'h4040);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd4, 32'h4040, 5'd0, 5'd0);
    nextCycle();
    expectWrite(5'd6, 32'h6666);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd6, 32'h6666, 5'd0, 5'd0);
    checkOutput("t5_lu_r6_ready", 64'(lu_wb_ready), 64'(1));
    nextCycle();
    idle();
    checkOutput("t5_err_sticky", 64'(err), 64'(1));
    nextCycle();

    // Scenario 6: asynchronous reset while in WAIT with r2 busy.
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    nextCycle();
    expectWrite(5'd11, 32'hB0B0);
    applyStimulus(1'b1, 5'd11, 32'hB0B0, 1'b0, 5'd0, 1'b1, 5'd2, 32'h2222, 5'd2, 5'd0);
    nextCycle();
    applyStimulus(1'b1, 5'd12, 32'hB1B1, 1'b0, 5'd2, 1'b1, 5'd2, 32'h2222, 5'd2, 5'd0);
    checkOutput("t6_hazard_pre", 64'(hazard), 64'(1));
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_rf_we", 64'(rf_we), 64'(0));
    checkOutput("t6_rst_lu_ready", 64'(lu_wb_ready), 64'(0));
    checkOutput("t6_rst_stall", 64'(pipe_stall), 64'(0));
    checkOutput("t6_rst_err", 64'(err), 64'(0));
    checkOutput("t6_rst_hazard", 64'(hazard), 64'(0));
    checkOutput("t6_rst_r2_free", 64'(lu_issue_ready), 64'(1));
    nextCycle();
    idle();
    rst = 1'b0;
    nextCycle();
    nextCycle();

    checkOutput("wb_q_drain", 64'(wb_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
